// File: rtl/switch_debounce_pair.sv
// Two-channel switch front end: 2-flop synchronizer plus debounce counter per pin,
// AND of the debounced levels on o_LED_1. Define SWITCH_DEBOUNCE_PAIR_EDGE_EN for press/release pulses.
module switch_debounce_pair #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_Switch_1,
    output logic o_Switch_2,
    output logic o_Press_1,
    output logic o_Press_2,
    output logic o_Release_1,
    output logic o_Release_2,
    output logic o_LED_1
);

    localparam int unsigned CW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic [1:0]    pin;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    accept;
    logic [CW-1:0] count [2];

    assign pin = {i_Switch_2, i_Switch_1};

    // A channel is accepted on the cycle its counter sits at the limit while still disagreeing.
    always_comb begin
        accept = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            accept[ch] = (sync2[ch] != stable[ch]) && (count[ch] == CNT_LAST);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            count[0] <= '0;
            count[1] <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (sync2[ch] == stable[ch]) begin
                    count[ch] <= '0;
                end else if (accept[ch]) begin
                    stable[ch] <= sync2[ch];
                    count[ch]  <= '0;
                end else begin
                    count[ch] <= count[ch] + 1'b1;
                end
            end
        end
    end

    assign o_Switch_1 = stable[0];
    assign o_Switch_2 = stable[1];
    assign o_LED_1    = stable[0] & stable[1];

`ifdef SWITCH_DEBOUNCE_PAIR_EDGE_EN
    logic [1:0] press_q;
    logic [1:0] rel_q;

    // Pulses register alongside stable so they coincide with the first cycle of the new level.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            press_q <= accept & sync2;
            rel_q   <= accept & ~sync2;
        end
    end

    assign o_Press_1   = press_q[0];
    assign o_Press_2   = press_q[1];
    assign o_Release_1 = rel_q[0];
    assign o_Release_2 = rel_q[1];
`else
    assign o_Press_1   = 1'b0;
    assign o_Press_2   = 1'b0;
    assign o_Release_1 = 1'b0;
    assign o_Release_2 = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_pair.sv
// Scoreboard bench for switch_debounce_pair with DEBOUNCE_LIMIT=4: stimulus queues the
// hand-derived output vector expected after each edge, a monitor pops and compares on negedge.
module tb_switch_debounce_pair;

    bit   clk = 1'b0;
    logic i_Reset;
    logic i_Switch_1;
    logic i_Switch_2;
    logic o_Switch_1, o_Switch_2;
    logic o_Press_1, o_Press_2;
    logic o_Release_1, o_Release_2;
    logic o_LED_1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Vector bits: [6]=led [5]=rel2 [4]=rel1 [3]=press2 [2]=press1 [1]=sw2 [0]=sw1
    logic [6:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    switch_debounce_pair #(.DEBOUNCE_LIMIT(4)) dut (
        .i_Clk       (clk),
        .i_Reset     (i_Reset),
        .i_Switch_1  (i_Switch_1),
        .i_Switch_2  (i_Switch_2),
        .o_Switch_1  (o_Switch_1),
        .o_Switch_2  (o_Switch_2),
        .o_Press_1   (o_Press_1),
        .o_Press_2   (o_Press_2),
        .o_Release_1 (o_Release_1),
        .o_Release_2 (o_Release_2),
        .o_LED_1     (o_LED_1)
    );

    function automatic logic [6:0] v(input logic sw1, sw2, p1, p2, r1, r2);
        logic [6:0] e;
        e = {sw1 & sw2, r2, r1, p2, p1, sw2, sw1};
`ifndef SWITCH_DEBOUNCE_PAIR_EDGE_EN
        e[5:2] = '0;
`endif
        return e;
    endfunction

    task automatic step(input logic rst, s1, s2, input logic [6:0] e, input string tag);
        i_Reset    = rst;
        i_Switch_1 = s1;
        i_Switch_2 = s2;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n, input logic rst, s1, s2, input logic [6:0] e, input string tag);
        for (int i = 0; i < n; i++) step(rst, s1, s2, e, tag);
    endtask

    initial begin : monitor
        logic [6:0] e, act;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                act = {o_LED_1, o_Release_2, o_Release_1, o_Press_2, o_Press_1, o_Switch_2, o_Switch_1};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s @%0t: got %b want %b (led,rel2,rel1,prs2,prs1,sw2,sw1)",
                             t, $time, act, e);
                end
            end
        end
    end

    initial begin : stimulus
        logic [6:0] Z, S1, S2, B, P1, P2, PB, R1, R2;
        Z  = v(0, 0, 0, 0, 0, 0);
        S1 = v(1, 0, 0, 0, 0, 0);
        S2 = v(0, 1, 0, 0, 0, 0);
        B  = v(1, 1, 0, 0, 0, 0);
        P1 = v(1, 0, 1, 0, 0, 0);
        P2 = v(1, 1, 0, 1, 0, 0);
        PB = v(1, 1, 1, 1, 0, 0);
        R1 = v(0, 0, 0, 0, 1, 0);
        R2 = v(1, 0, 0, 0, 0, 1);

        // Reset held with both pins high, then release: levels rise on the 6th edge.
        hold(3, 1, 1, 1, Z, "reset_hold");
        hold(5, 0, 1, 1, Z, "post_reset_wait");
        step(0, 1, 1, PB, "post_reset_press");
        hold(2, 0, 1, 1, B, "post_reset_level");
        hold(2, 1, 0, 0, Z, "reset_clear");
        hold(2, 0, 0, 0, Z, "idle");

        // Clean press and release on channel 1.
        hold(5, 0, 1, 0, Z, "press1_wait");
        step(0, 1, 0, P1, "press1_accept");
        hold(3, 0, 1, 0, S1, "press1_level");
        hold(5, 0, 0, 0, S1, "release1_wait");
        step(0, 0, 0, R1, "release1_accept");
        hold(2, 0, 0, 0, Z, "release1_level");

        // Bounce 1,1,1,0 then steady 1: accepted on the 10th edge.
        hold(3, 0, 1, 0, Z, "bounce_pre");
        step(0, 0, 0, Z, "bounce_low");
        hold(5, 0, 1, 0, Z, "bounce_wait");
        step(0, 1, 0, P1, "bounce_accept");
        hold(2, 0, 1, 0, S1, "bounce_level");
        hold(5, 0, 0, 0, S1, "bounce_rel_wait");
        step(0, 0, 0, R1, "bounce_release");
        step(0, 0, 0, Z, "bounce_idle");

        // Three-cycle glitch on channel 2 reaches limit-1 and is discarded.
        hold(3, 0, 0, 1, Z, "glitch_high");
        hold(7, 0, 0, 0, Z, "glitch_low");

        // Simultaneous press, then drop channel 2.
        hold(5, 0, 1, 1, Z, "both_wait");
        step(0, 1, 1, PB, "both_accept");
        hold(2, 0, 1, 1, B, "both_level");
        hold(5, 0, 1, 0, B, "drop2_wait");
        step(0, 1, 0, R2, "drop2_accept");
        hold(2, 0, 1, 0, S1, "drop2_level");

        // Reset on the acceptance edge wins, then a full count restarts.
        step(1, 0, 0, Z, "clear");
        hold(5, 0, 1, 0, Z, "midreset_wait");
        step(1, 1, 0, Z, "reset_on_accept");
        hold(5, 0, 1, 0, Z, "restart_wait");
        step(0, 1, 0, P1, "restart_accept");
        step(0, 1, 0, S1, "restart_level");

        // Channel 2 alone while channel 1 holds high.
        hold(5, 0, 1, 1, S1, "press2_wait");
        step(0, 1, 1, P2, "press2_accept");
        step(0, 1, 1, B, "press2_level");
        hold(2, 0, 1, 1, B, "tail");

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
